bin2bcd_seq: RTL and testbench

Sequential double-dabble converter that turns a 12-bit binary count into four BCD digits (thousands, hundreds, tens, ones). It sits directly upstream of the four-digit seven-segment display driver, so the display no longer needs combinational `/` and `%` arithmetic. It runs in the display clock domain and uses a valid/ready input handshake. Output digit registers hold the last result between conversions.

---
 rtl/bin2bcd_seq_pkg.sv | 48 ++++
 rtl/bin2bcd_seq_bcd_add3.sv | 20 ++
 rtl/bin2bcd_seq.sv | 109 ++++++++++
 tb/tb_bin2bcd_seq.sv | 206 ++++++++++++++++++++
 4 files changed

// File: rtl/bin2bcd_seq_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : bin2bcd_seq_pkg
//  Description : Shared constants, state encoding and the leading-zero
//                blanking helper for the sequential binary-to-BCD converter.
//                Optional feature macro: BCD_BLANK_EN.
//  Revision    : 1.0  initial release
// ============================================================================
package bin2bcd_seq_pkg;

    // Binary input width and number of BCD digits produced
    localparam int BIN_W  = 12;
    localparam int DIGITS = 4;

    // BCD field width and full double-dabble scratch width
    localparam int BCD_W  = 4 * DIGITS;
    localparam int SCR_W  = BCD_W + BIN_W;

    // Digit code the display renders as all segments off
    localparam logic [3:0] BLANK_CODE = 4'hF;

    // Counter value on the final (12th) shift
    localparam logic [3:0] ITER_LAST  = 4'd11;

    // FSM state encoding
    typedef logic [0:0] state_t;
    localparam state_t ST_IDLE  = 1'b0;
    localparam state_t ST_SHIFT = 1'b1;

    // Replace leading zero digits with BLANK_CODE, scanning from the most
    // significant digit down; the ones digit is never blanked.
    function automatic logic [BCD_W-1:0] blank_leading(input logic [BCD_W-1:0] d);
        logic [BCD_W-1:0] res;
        logic             leading;
        res     = d;
        leading = 1'b1;
        for (int i = DIGITS - 1; i > 0; i--) begin
            if (leading && (d[4*i +: 4] == 4'd0)) begin
                res[4*i +: 4] = BLANK_CODE;
            end else begin
                leading = 1'b0;
            end
        end
        return res;
    endfunction

endpackage
`default_nettype wire

// File: rtl/bin2bcd_seq_bcd_add3.sv
`default_nettype none
// ============================================================================
//  Module      : bcd_add3
//  Description : Combinational double-dabble cell: adds 3 to a BCD nibble
//                whose value is 5 or more, so the following left shift
//                carries correctly into the next decimal digit.
//  Revision    : 1.0  initial release
// ============================================================================
module bcd_add3 (
    input  logic [3:0] i_nib,
    output logic [3:0] o_nib
);

    // Correct the nibble ahead of the shift
    always_comb begin
        o_nib = (i_nib >= 4'd5) ? (i_nib + 4'd3) : i_nib;
    end

endmodule
`default_nettype wire

// File: rtl/bin2bcd_seq.sv
`default_nettype none
// ============================================================================
//  Module      : bin2bcd_seq
//  Description : Sequential double-dabble converter, 12-bit binary to four
//                BCD digits, one shift per clock, valid/ready input. Result
//                digits are held between conversions.
//                Optional feature macro: BCD_BLANK_EN (leading-zero blanking
//                of the written digits).
//  Revision    : 1.0  initial release
// ============================================================================
module bin2bcd_seq
    import bin2bcd_seq_pkg::*;
(
    input  logic             clk120,
    input  logic             rst,
    input  logic [BIN_W-1:0] bin_in,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [3:0]       ones,
    output logic [3:0]       tens,
    output logic [3:0]       hundreds,
    output logic [3:0]       thousands,
    output logic             out_valid,
    output logic             busy
);

    state_t             r_state;
    logic [3:0]         r_cnt;
    logic [SCR_W-1:0]   r_scr;
    logic [BCD_W-1:0]   r_digits;
    logic               r_out_valid;

    logic [BCD_W-1:0]   w_adj_bcd;
    logic [SCR_W-1:0]   w_scr_next;
    logic [BCD_W-1:0]   w_dig_out;

    // One add-3 correction cell per BCD nibble of the scratch register
    generate
        for (genvar g = 0; g < DIGITS; g++) begin : g_add3
            bcd_add3 u_add3 (
                .i_nib (r_scr[BIN_W + 4*g +: 4]),
                .o_nib (w_adj_bcd[4*g +: 4])
            );
        end
    endgenerate

    // Corrected BCD field plus untouched binary field, shifted left by one
    always_comb begin
        w_scr_next = {w_adj_bcd[BCD_W-2:0], r_scr[BIN_W-1:0], 1'b0};
    end

    // Digits as written on the final shift, optionally leading-zero blanked
`ifdef BCD_BLANK_EN
    always_comb begin
        w_dig_out = blank_leading(w_scr_next[SCR_W-1:BIN_W]);
    end
`else
    always_comb begin
        w_dig_out = w_scr_next[SCR_W-1:BIN_W];
    end
`endif

    // Control FSM, scratch shifter and result registers
    always_ff @(posedge clk120) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_cnt       <= 4'd0;
            r_scr       <= '0;
            r_digits    <= '0;
            r_out_valid <= 1'b0;
        end else begin
            r_out_valid <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (in_valid) begin
                        r_scr   <= {{BCD_W{1'b0}}, bin_in};
                        r_cnt   <= 4'd0;
                        r_state <= ST_SHIFT;
                    end
                end
                ST_SHIFT: begin
                    r_scr <= w_scr_next;
                    r_cnt <= r_cnt + 4'd1;
                    if (r_cnt == ITER_LAST) begin
                        r_digits    <= w_dig_out;
                        r_out_valid <= 1'b1;
                        r_state     <= ST_IDLE;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    // Status and digit outputs
    always_comb begin
        in_ready  = (r_state == ST_IDLE);
        busy      = (r_state == ST_SHIFT);
        out_valid = r_out_valid;
        thousands = r_digits[15:12];
        hundreds  = r_digits[11:8];
        tens      = r_digits[7:4];
        ones      = r_digits[3:0];
    end

endmodule
`default_nettype wire

// File: tb/tb_bin2bcd_seq.sv
`default_nettype none
// ============================================================================
//  Module      : tb_bin2bcd_seq
//  Description : Scoreboard bench for bin2bcd_seq. Expected digits are
//                pushed when an accept is predicted and popped on out_valid.
//                Honours BCD_BLANK_EN in the reference model.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_bin2bcd_seq;

    logic        clk120;
    logic        rst;
    logic [11:0] bin_in;
    logic        in_valid;
    logic        in_ready;
    logic [3:0]  ones, tens, hundreds, thousands;
    logic        out_valid;
    logic        busy;

    typedef struct {
        logic [15:0] digits;
        int          acc_edge;
    } sb_t;

    sb_t sb[$];
    int  edge_cnt  = 0;
    int  ov_count  = 0;
    int  checks    = 0;
    int  errors    = 0;

    bin2bcd_seq u_dut (
        .clk120    (clk120),
        .rst       (rst),
        .bin_in    (bin_in),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .ones      (ones),
        .tens      (tens),
        .hundreds  (hundreds),
        .thousands (thousands),
        .out_valid (out_valid),
        .busy      (busy)
    );

    initial clk120 = 1'b0;
    always #5 clk120 = ~clk120;

    always @(posedge clk120) edge_cnt <= edge_cnt + 1;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reference conversion by division, independent of double-dabble
    function automatic logic [15:0] model(input int v);
        logic [15:0] d;
        d[15:12] = 4'((v / 1000) % 10);
        d[11:8]  = 4'((v / 100) % 10);
        d[7:4]   = 4'((v / 10) % 10);
        d[3:0]   = 4'(v % 10);
`ifdef BCD_BLANK_EN
        if (d[15:12] == 4'd0) begin
            d[15:12] = 4'hF;
            if (d[11:8] == 4'd0) begin
                d[11:8] = 4'hF;
                if (d[7:4] == 4'd0) d[7:4] = 4'hF;
            end
        end
`endif
        return d;
    endfunction

    // Scoreboard monitor: compare on out_valid, predict accepts for next edge
    always @(negedge clk120) begin
        sb_t e;
        if (out_valid) begin
            ov_count++;
            if (sb.size() == 0) begin
                chk("unexpected_out_valid", 32'd1, 32'd0);
            end else begin
                e = sb.pop_front();
                chk("digits", {16'h0, thousands, hundreds, tens, ones}, {16'h0, e.digits});
                chk("latency", edge_cnt - e.acc_edge, 32'd12);
            end
        end
        if (rst) begin
            sb.delete();
        end else if (in_valid && in_ready) begin
            e.digits   = model(int'(bin_in));
            e.acc_edge = edge_cnt + 1;
            sb.push_back(e);
        end
    end

    // Present a value and hold in_valid until the accepting edge
    task automatic send(input logic [11:0] v, output int acc);
        logic was_ready;
        int   n;
        in_valid = 1'b1;
        bin_in   = v;
        n        = 0;
        do begin
            was_ready = in_ready;
            @(posedge clk120); #1;
            n++;
        end while (!was_ready && n < 40);
        if (!was_ready) chk("accept_timeout", 32'd0, 32'd1);
        acc      = edge_cnt;
        in_valid = 1'b0;
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 40; i++) begin
            if (sb.size() == 0 && !busy) break;
            @(posedge clk120); #1;
        end
        chk("drain", sb.size(), 32'd0);
    endtask

    initial begin
        int a1, a2, ovb;
        int vals[6] = '{9, 10, 99, 100, 999, 1000};
        rst      = 1'b1;
        in_valid = 1'b0;
        bin_in   = '0;
        repeat (3) @(posedge clk120);
        #1;
        chk("rst_digits", {16'h0, thousands, hundreds, tens, ones}, 32'h0);
        chk("rst_out_valid", out_valid, 1'b0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_in_ready", in_ready, 1'b1);
        rst = 1'b0;
        @(posedge clk120); #1;

        // Zero and full scale
        send(12'd0, a1);
        wait_idle();
        send(12'd4095, a1);
        chk("busy_after_accept", busy, 1'b1);
        chk("ready_after_accept", in_ready, 1'b0);
        wait_idle();

        // Back-to-back with in_valid held
        send(12'd1234, a1);
        send(12'd7, a2);
        chk("b2b_gap", a2 - a1, 32'd13);
        wait_idle();

        // Input ignored while busy
        send(12'd50, a1);
        in_valid = 1'b1;
        bin_in   = 12'd999;
        for (int i = 0; i < 5; i++) begin
            chk("ready_while_busy", in_ready, 1'b0);
            @(posedge clk120); #1;
        end
        in_valid = 1'b0;
        wait_idle();

        // Reset mid-conversion
        send(12'd3210, a1);
        repeat (5) begin @(posedge clk120); #1; end
        rst = 1'b1;
        @(posedge clk120); #1;
        rst = 1'b0;
        chk("abort_in_ready", in_ready, 1'b1);
        chk("abort_busy", busy, 1'b0);
        chk("abort_digits", {16'h0, thousands, hundreds, tens, ones}, 32'h0);
        ovb = ov_count;
        repeat (15) begin @(posedge clk120); #1; end
        chk("abort_no_out_valid", ov_count - ovb, 32'd0);
        send(12'd3210, a1);
        wait_idle();

        // Reset wins over in_valid
        rst      = 1'b1;
        in_valid = 1'b1;
        bin_in   = 12'd5;
        @(posedge clk120); #1;
        rst      = 1'b0;
        in_valid = 1'b0;
        chk("rst_valid_busy", busy, 1'b0);
        @(posedge clk120); #1;
        chk("rst_valid_busy2", busy, 1'b0);

        // Decade boundaries and random values
        foreach (vals[i]) begin
            send(12'(vals[i]), a1);
            wait_idle();
        end
        for (int i = 0; i < 6; i++) begin
            send(12'($urandom_range(0, 4095)), a1);
            wait_idle();
        end

        repeat (2) @(posedge clk120);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
